// File: rtl/swipt_pkg.sv
// swipt_pkg: shared widths, clamp limits and FSM encoding for the SWIPT drive chain
package swipt_pkg;
  localparam int FREQ_W = 20;
  localparam int HP_W = 16;
  localparam logic [FREQ_W-1:0] FREQ_MIN = 20'h7530;
  localparam logic [FREQ_W-1:0] FREQ_MAX = 20'hC350;
  localparam logic [FREQ_W-1:0] SWEEP_START = 20'h88B8;
  localparam logic [FREQ_W-1:0] SWEEP_LIMIT = 20'hAFC8;
  typedef enum logic [1:0] {IDLE, CALC, RUN} state_t;
  function automatic logic [FREQ_W-1:0] clamp_freq(input logic [FREQ_W-1:0] f,
                                                   input logic [FREQ_W-1:0] lo,
                                                   input logic [FREQ_W-1:0] hi);
    return f < lo ? lo : (f > hi ? hi : f);
  endfunction
endpackage

// File: rtl/swipt_drive_gen_if.sv
// swipt_drive_gen_if: control/status bundle between the sweep stage and the bridge driver
interface swipt_drive_gen_if;
  import swipt_pkg::*;
  logic enable;
  logic [FREQ_W-1:0] freq_in;
  logic drive_p;
  logic drive_n;
  logic [FREQ_W-1:0] freq_active;
  logic [HP_W-1:0] half_period;
  logic busy;
  logic applied;
  modport master (output enable, freq_in,
                  input drive_p, drive_n, freq_active, half_period, busy, applied);
  modport slave (input enable, freq_in,
                 output drive_p, drive_n, freq_active, half_period, busy, applied);
endinterface

// File: rtl/swipt_seq_div.sv
// swipt_seq_div: restoring divider, one quotient bit per clock, abortable
module swipt_seq_div #(
  parameter int DVD_W = 27,
  parameter int DVS_W = 21,
  parameter int Q_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Q_W-1:0]   quot_o
);
  localparam int IT_W = $clog2(DVD_W + 1);
  logic [DVD_W-1:0] quo_q;
  logic [DVS_W-1:0] rem_q, dvs_q;
  logic [IT_W-1:0] it_q;
  logic busy_q, done_q, ge;
  logic [DVS_W:0] rem_sh;
  assign rem_sh = {rem_q, quo_q[DVD_W-1]};
  assign ge = rem_sh >= {1'b0, dvs_q};
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign quot_o = quo_q[Q_W-1:0];
  // operands latch on start; dividend bits shift out as quotient bits shift in
  always_ff @(posedge clk) begin
    if (!nrst || abort_i) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      it_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      done_q <= 1'b0;
      it_q <= IT_W'(DVD_W);
      quo_q <= dividend_i;
      rem_q <= '0;
      dvs_q <= divisor_i;
    end else begin
      done_q <= busy_q && it_q == IT_W'(1);
      if (busy_q) begin
        quo_q <= {quo_q[DVD_W-2:0], ge};
        rem_q <= DVS_W'(ge ? rem_sh - {1'b0, dvs_q} : rem_sh);
        it_q <= it_q - 1'b1;
        busy_q <= it_q != IT_W'(1);
      end
    end
  end
endmodule

// File: rtl/swipt_drive_gen.sv
// swipt_drive_gen: frequency-to-half-period bridge driver with dead time (SWIPT_SOFT_START_EN adds soft-start dead time)
module swipt_drive_gen
  import swipt_pkg::*;
#(
  parameter int CLK_HZ = 100000000,
  parameter int DEAD_CYCLES = 20
`ifdef SWIPT_SOFT_START_EN
  , parameter int SOFT_DEAD = 200
`endif
) (
  input logic clk,
  input logic nrst,
  swipt_drive_gen_if.slave bus
);
  localparam logic [26:0] DIVIDEND = 27'(CLK_HZ);
  state_t state_q, state_d;
  logic [HP_W-1:0] cnt_q, cnt_d, hp_q, hp_d, pend_hp_q, pend_hp_d, quot, dead_d;
  logic [FREQ_W-1:0] fa_q, fa_d, pend_f_q, pend_f_d, op_q, op_d, f_c;
  logic ph_q, ph_d, pend_v_q, pend_v_d, start_q, start_d, applied_q, applied_d;
  logic drive_p_q, drive_p_d, drive_n_q, drive_n_d;
  logic div_busy, div_done, wrap, entry, np_wrap;
  assign f_c = clamp_freq(bus.freq_in, FREQ_MIN, FREQ_MAX);
  assign wrap = cnt_q == hp_q - 1'b1;
  assign entry = bus.enable && state_q == CALC && div_done;
  assign np_wrap = bus.enable && state_q == RUN && wrap && ph_q;
  assign bus.drive_p = drive_p_q;
  assign bus.drive_n = drive_n_q;
  assign bus.freq_active = fa_q;
  assign bus.half_period = hp_q;
  assign bus.applied = applied_q;
  assign bus.busy = start_q | div_busy | div_done | pend_v_q;
  swipt_seq_div #(.DVD_W(27), .DVS_W(21), .Q_W(HP_W)) u_div (
    .clk,
    .nrst,
    .start_i(start_q),
    .abort_i(!bus.enable),
    .dividend_i(DIVIDEND),
    .divisor_i({op_q, 1'b0}),
    .busy_o(div_busy),
    .done_o(div_done),
    .quot_o(quot)
  );
`ifdef SWIPT_SOFT_START_EN
  logic [HP_W-1:0] dead_q;
  // dead time restarts wide on each run entry and narrows one clock per full period
  always_ff @(posedge clk) dead_q <= !nrst ? HP_W'(DEAD_CYCLES) : dead_d;
  // next dead time
  always_comb dead_d = entry ? HP_W'(SOFT_DEAD) :
                       (np_wrap && dead_q != HP_W'(DEAD_CYCLES)) ? dead_q - 1'b1 : dead_q;
`else
  assign dead_d = HP_W'(DEAD_CYCLES);
`endif
  // sequencing: divide launch, half-period counting, pending apply at full-period boundary
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ph_d = ph_q;
    hp_d = hp_q;
    fa_d = fa_q;
    pend_hp_d = pend_hp_q;
    pend_f_d = pend_f_q;
    pend_v_d = pend_v_q;
    op_d = op_q;
    start_d = 1'b0;
    applied_d = 1'b0;
    if (!bus.enable) begin
      state_d = IDLE;
      pend_v_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = CALC;
          start_d = 1'b1;
          op_d = f_c;
        end
        CALC: if (entry) begin
          state_d = RUN;
          hp_d = quot;
          fa_d = op_q;
          applied_d = 1'b1;
          cnt_d = '0;
          ph_d = 1'b0;
        end
        RUN: begin
          cnt_d = wrap ? '0 : cnt_q + 1'b1;
          ph_d = wrap ? ~ph_q : ph_q;
          if (np_wrap && pend_v_q) begin
            hp_d = pend_hp_q;
            fa_d = pend_f_q;
            applied_d = 1'b1;
            pend_v_d = 1'b0;
          end
          if (div_done) begin
            pend_hp_d = quot;
            pend_f_d = op_q;
            pend_v_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (state_q != IDLE && !div_busy && !start_q && f_c != op_q) begin
        start_d = 1'b1;
        op_d = f_c;
      end
    end
    drive_p_d = state_d == RUN && !ph_d && cnt_d >= dead_d;
    drive_n_d = state_d == RUN && ph_d && cnt_d >= dead_d;
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ph_q <= 1'b0;
      hp_q <= '0;
      fa_q <= '0;
      pend_hp_q <= '0;
      pend_f_q <= '0;
      pend_v_q <= 1'b0;
      op_q <= '0;
      start_q <= 1'b0;
      applied_q <= 1'b0;
      drive_p_q <= 1'b0;
      drive_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ph_q <= ph_d;
      hp_q <= hp_d;
      fa_q <= fa_d;
      pend_hp_q <= pend_hp_d;
      pend_f_q <= pend_f_d;
      pend_v_q <= pend_v_d;
      op_q <= op_d;
      start_q <= start_d;
      applied_q <= applied_d;
      drive_p_q <= drive_p_d;
      drive_n_q <= drive_n_d;
    end
  end
endmodule

// File: tb/tb_swipt_drive_gen.sv
// tb_swipt_drive_gen: directed self-checking bench for swipt_drive_gen (default build, SWIPT_SOFT_START_EN undefined)
module tb_swipt_drive_gen;
  import swipt_pkg::*;
  logic clk = 1'b0;
  logic nrst;
  int checks = 0;
  int errors = 0;
  int app_cnt = 0;
  int overlap = 0;
  int seen40 = 0;
  int n_run = 0;
  int n_last = 0;
  swipt_drive_gen_if bus();
  swipt_drive_gen dut (.clk(clk), .nrst(nrst), .bus(bus));
  always #5 clk = ~clk;
  // passive monitors sampled on the falling edge
  always @(negedge clk) begin
    if (bus.applied) app_cnt <= app_cnt + 1;
    if (bus.drive_p && bus.drive_n) overlap <= overlap + 1;
    if (bus.freq_active == 20'd40000) seen40 <= seen40 + 1;
    if (bus.drive_n) n_run <= n_run + 1;
    else if (n_run != 0) begin
      n_last <= n_run;
      n_run <= 0;
    end
  end
  task automatic wait_applied(input int lim, output int cyc, output bit ok);
    cyc = 0;
    ok = 1'b0;
    while (!ok && cyc < lim) begin
      @(negedge clk);
      cyc++;
      ok = bus.applied;
    end
  endtask
  task automatic measure_p(output int hi, output int lo, output bit ok);
    int n = 0;
    hi = 0;
    lo = 0;
    while (!bus.drive_p && n < 4000) begin @(negedge clk); n++; end
    while (bus.drive_p && hi < 4000) begin @(negedge clk); hi++; end
    while (!bus.drive_p && lo < 4000) begin @(negedge clk); lo++; end
    ok = n < 4000 && hi < 4000 && lo < 4000;
  endtask
  task automatic test_reset();
    nrst = 1'b0;
    bus.enable = 1'b0;
    bus.freq_in = SWEEP_START;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.drive_p, bus.drive_n} !== 2'b00) begin
      errors++;
      $display("FAIL reset_drive got p=%b n=%b want 0 0", bus.drive_p, bus.drive_n);
    end
    checks++;
    if (bus.freq_active !== 20'd0) begin
      errors++;
      $display("FAIL reset_freq_active got %0d want 0", bus.freq_active);
    end
    checks++;
    if (bus.half_period !== 16'd0) begin
      errors++;
      $display("FAIL reset_half_period got %0d want 0", bus.half_period);
    end
    checks++;
    if ({bus.busy, bus.applied} !== 2'b00) begin
      errors++;
      $display("FAIL reset_busy_applied got %b%b want 00", bus.busy, bus.applied);
    end
    nrst = 1'b1;
  endtask
  task automatic test_startup();
    int cyc, hi, lo, a0;
    bit ok;
    a0 = app_cnt;
    bus.enable = 1'b1;
    wait_applied(100, cyc, ok);
    checks++;
    if (!ok || cyc < 28 || cyc > 31) begin
      errors++;
      $display("FAIL startup_latency got ok=%b cyc=%0d want 28..31", ok, cyc);
    end
    checks++;
    if (bus.half_period !== 16'd1428) begin
      errors++;
      $display("FAIL startup_half_period got %0d want 1428", bus.half_period);
    end
    checks++;
    if (bus.freq_active !== 20'd35000) begin
      errors++;
      $display("FAIL startup_freq_active got %0d want 35000", bus.freq_active);
    end
    measure_p(hi, lo, ok);
    checks++;
    if (!ok || hi != 1408) begin
      errors++;
      $display("FAIL startup_p_high got %0d want 1408", hi);
    end
    checks++;
    if (lo != 1448) begin
      errors++;
      $display("FAIL startup_p_low got %0d want 1448", lo);
    end
    checks++;
    if (app_cnt - a0 != 1) begin
      errors++;
      $display("FAIL startup_applied_pulses got %0d want 1", app_cnt - a0);
    end
  endtask
  task automatic test_retune();
    int cyc, hi, lo;
    bit ok;
    bus.freq_in = SWEEP_LIMIT;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL retune_busy_start got %b want 1", bus.busy);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (bus.half_period !== 16'd1428 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL retune_pending got hp=%0d busy=%b want 1428 1", bus.half_period, bus.busy);
    end
    wait_applied(4000, cyc, ok);
    @(negedge clk);
    checks++;
    if (!ok || bus.half_period !== 16'd1111 || bus.freq_active !== 20'd45000) begin
      errors++;
      $display("FAIL retune_apply got ok=%b hp=%0d f=%0d want 1 1111 45000", ok, bus.half_period, bus.freq_active);
    end
    checks++;
    if (n_last != 1408) begin
      errors++;
      $display("FAIL retune_last_n_pulse got %0d want 1408", n_last);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL retune_busy_clear got %b want 0", bus.busy);
    end
    measure_p(hi, lo, ok);
    checks++;
    if (!ok || hi != 1091 || lo != 1131) begin
      errors++;
      $display("FAIL retune_p_shape got hi=%0d lo=%0d want 1091 1131", hi, lo);
    end
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL retune_overlap got %0d want 0", overlap);
    end
  endtask
  task automatic test_clamp();
    int cyc;
    bit ok;
    bus.freq_in = 20'd10000;
    wait_applied(5000, cyc, ok);
    checks++;
    if (!ok || bus.half_period !== 16'd1666 || bus.freq_active !== 20'd30000) begin
      errors++;
      $display("FAIL clamp_low got ok=%b hp=%0d f=%0d want 1 1666 30000", ok, bus.half_period, bus.freq_active);
    end
    bus.freq_in = 20'd60000;
    wait_applied(5000, cyc, ok);
    checks++;
    if (!ok || bus.half_period !== 16'd1000 || bus.freq_active !== 20'd50000) begin
      errors++;
      $display("FAIL clamp_high got ok=%b hp=%0d f=%0d want 1 1000 50000", ok, bus.half_period, bus.freq_active);
    end
  endtask
  task automatic test_latest_wins();
    int cyc, a0, s0;
    bit ok;
    bus.enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.drive_p, bus.drive_n, bus.busy} !== 3'b000) begin
      errors++;
      $display("FAIL disable_outputs got p=%b n=%b busy=%b want 000", bus.drive_p, bus.drive_n, bus.busy);
    end
    @(negedge clk);
    a0 = app_cnt;
    s0 = seen40;
    bus.freq_in = SWEEP_START;
    bus.enable = 1'b1;
    repeat (3) @(negedge clk);
    bus.freq_in = 20'd40000;
    repeat (5) @(negedge clk);
    bus.freq_in = SWEEP_LIMIT;
    wait_applied(100, cyc, ok);
    checks++;
    if (!ok || bus.freq_active !== 20'd35000 || bus.half_period !== 16'd1428) begin
      errors++;
      $display("FAIL latest_first got ok=%b f=%0d hp=%0d want 1 35000 1428", ok, bus.freq_active, bus.half_period);
    end
    wait_applied(4000, cyc, ok);
    checks++;
    if (!ok || bus.freq_active !== 20'd45000 || bus.half_period !== 16'd1111) begin
      errors++;
      $display("FAIL latest_second got ok=%b f=%0d hp=%0d want 1 45000 1111", ok, bus.freq_active, bus.half_period);
    end
    @(negedge clk);
    checks++;
    if (app_cnt - a0 != 2 || seen40 != s0) begin
      errors++;
      $display("FAIL latest_skip got pulses=%0d seen40=%0d want 2 0", app_cnt - a0, seen40 - s0);
    end
  endtask
  task automatic test_abort_reset();
    int cyc;
    bit ok;
    bus.enable = 1'b0;
    repeat (2) @(negedge clk);
    bus.freq_in = 20'd40000;
    bus.enable = 1'b1;
    repeat (10) @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.drive_p, bus.drive_n, bus.busy} !== 3'b000) begin
      errors++;
      $display("FAIL abort_outputs got p=%b n=%b busy=%b want 000", bus.drive_p, bus.drive_n, bus.busy);
    end
    checks++;
    if (bus.freq_active !== 20'd45000 || bus.half_period !== 16'd1111) begin
      errors++;
      $display("FAIL abort_hold got f=%0d hp=%0d want 45000 1111", bus.freq_active, bus.half_period);
    end
    bus.enable = 1'b1;
    wait_applied(100, cyc, ok);
    checks++;
    if (!ok || bus.freq_active !== 20'd40000 || bus.half_period !== 16'd1250) begin
      errors++;
      $display("FAIL reenable got ok=%b f=%0d hp=%0d want 1 40000 1250", ok, bus.freq_active, bus.half_period);
    end
    cyc = 0;
    while (!bus.drive_p && cyc < 100) begin @(negedge clk); cyc++; end
    checks++;
    if (bus.drive_p !== 1'b1) begin
      errors++;
      $display("FAIL reenable_drive got %b want 1", bus.drive_p);
    end
    nrst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.drive_p, bus.drive_n, bus.busy, bus.applied} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_run_outputs got p=%b n=%b busy=%b ap=%b want 0000", bus.drive_p, bus.drive_n, bus.busy, bus.applied);
    end
    checks++;
    if (bus.freq_active !== 20'd0 || bus.half_period !== 16'd0) begin
      errors++;
      $display("FAIL rst_run_regs got f=%0d hp=%0d want 0 0", bus.freq_active, bus.half_period);
    end
    bus.enable = 1'b0;
    nrst = 1'b1;
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_startup();
    test_retune();
    test_clamp();
    test_latest_wins();
    test_abort_reset();
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL overlap_total got %0d want 0", overlap);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
